elevator_call_queue: RTL

ELEVATOR_CALL_QUEUE -- requirements
Module: elevator_call_queue

---
 rtl/elevator_call_queue.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/elevator_call_queue.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_call_queue
//  Description : Pending-call register for one elevator car. Accepts floor
//                call requests (floors 0..6), flags illegal floor 7 requests,
//                and runs a door sequence IDLE -> DWELL -> CLOSE whenever
//                the car arrives at a floor that has a pending call.
//  Ports       :
//      clk            - single clock, rising edge
//      rst            - synchronous active-high reset
//      req_valid      - call request present
//      req_floor[2:0] - requested floor (7 is illegal)
//      req_ready      - requests accepted (low only during reset)
//      req_err        - one-cycle pulse after an illegal request
//      car_floor[2:0] - floor the car occupies
//      car_arrived    - one-cycle pulse: car stopped at car_floor
//      queue_status   - pending-call bit vector, bit n = floor n
//      queue_empty    - queue_status == 0
//      pending_count  - number of set bits in queue_status
//      door_open      - door-open command
//      served_valid   - one-cycle pulse: call fully served
//      served_floor   - floor served, valid with served_valid
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_call_queue #(
    parameter int DWELL_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [2:0] req_floor,
    output logic       req_ready,
    output logic       req_err,
    input  logic [2:0] car_floor,
    input  logic       car_arrived,
    output logic [6:0] queue_status,
    output logic       queue_empty,
    output logic [2:0] pending_count,
    output logic       door_open,
    output logic       served_valid,
    output logic [2:0] served_floor
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_CLOSE = 2'd2
    } state_t;

    localparam logic [7:0] c_DWELL_LAST = 8'(DWELL_CYCLES - 1);
    localparam logic [2:0] c_BAD_FLOOR  = 3'd7;

    state_t     r_state;
    logic [7:0] r_dwell_cnt;
    logic [2:0] r_svc_floor;
    logic [6:0] r_queue;
    logic       r_queue_empty;
    logic [2:0] r_pending;
    logic       r_req_ready;
    logic       r_req_err;
    logic       r_door_open;
    logic       r_served_valid;
    logic [2:0] r_served_floor;

    logic       w_take;
    logic       w_serve;
    logic [6:0] w_set;
    logic [6:0] w_clr;
    logic [6:0] w_next_q;

    function automatic logic [2:0] popcount7(input logic [6:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 7; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

    always_comb begin
        w_take  = req_valid && r_req_ready;
        // Service starts only from IDLE and only for a floor already pending
        // before this edge; a same-edge request cannot trigger service.
        w_serve = (r_state == ST_IDLE) && car_arrived &&
                  (car_floor != c_BAD_FLOOR) && r_queue[car_floor];
        w_set   = 7'd0;
        w_clr   = 7'd0;
        // A request for the floor whose door is currently open is redundant.
        if (w_take && (req_floor != c_BAD_FLOOR) &&
            !((r_state == ST_DWELL) && (req_floor == r_svc_floor))) begin
            w_set = 7'd1 << req_floor;
        end
        if (w_serve) begin
            w_clr = 7'd1 << car_floor;
        end
        // Clear applied after set so a same-edge clear wins.
        w_next_q = (r_queue | w_set) & ~w_clr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_dwell_cnt    <= 8'd0;
            r_svc_floor    <= 3'd0;
            r_queue        <= 7'd0;
            r_queue_empty  <= 1'b1;
            r_pending      <= 3'd0;
            r_req_ready    <= 1'b0;
            r_req_err      <= 1'b0;
            r_door_open    <= 1'b0;
            r_served_valid <= 1'b0;
            r_served_floor <= 3'd0;
        end else begin
            r_queue        <= w_next_q;
            r_queue_empty  <= (w_next_q == 7'd0);
            r_pending      <= popcount7(w_next_q);
            r_req_ready    <= 1'b1;
            r_req_err      <= w_take && (req_floor == c_BAD_FLOOR);
            r_served_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_serve) begin
                        r_state     <= ST_DWELL;
                        r_svc_floor <= car_floor;
                        r_door_open <= 1'b1;
                        r_dwell_cnt <= 8'd0;
                    end
                end
                ST_DWELL: begin
                    // Counter value k marks the (k+1)-th open cycle.
                    if (r_dwell_cnt == c_DWELL_LAST) begin
                        r_state        <= ST_CLOSE;
                        r_door_open    <= 1'b0;
                        r_served_valid <= 1'b1;
                        r_served_floor <= r_svc_floor;
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + 8'd1;
                    end
                end
                ST_CLOSE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_door_open <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign req_err       = r_req_err;
    assign queue_status  = r_queue;
    assign queue_empty   = r_queue_empty;
    assign pending_count = r_pending;
    assign door_open     = r_door_open;
    assign served_valid  = r_served_valid;
    assign served_floor  = r_served_floor;

endmodule
`default_nettype wire
